// File: rtl/delay_pkg.sv
// delay_pkg: shared types and constants for the delay-register configure/verify sequencer.
`default_nettype none
package delay_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        WRESP  = 3'd2,
        RADDR  = 3'd3,
        RDATA  = 3'd4,
        NEXT   = 3'd5,
        FINISH = 3'd6
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
    localparam logic [1:0] ERR_BRESP    = 2'd1;
    localparam logic [1:0] ERR_RRESP    = 2'd2;
    localparam logic [1:0] ERR_MISMATCH = 2'd3;

    localparam logic [31:0] REG_OFS0 = 32'h0;
    localparam logic [31:0] REG_OFS1 = 32'h4;
    localparam logic [31:0] REG_OFS2 = 32'h8;
    localparam logic [31:0] REG_OFS3 = 32'hC;

    function automatic logic [31:0] reg_offset(input logic [1:0] i);
        case (i)
            2'd0:    reg_offset = REG_OFS0;
            2'd1:    reg_offset = REG_OFS1;
            2'd2:    reg_offset = REG_OFS2;
            default: reg_offset = REG_OFS3;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_cfg_seq.sv
// delay_cfg_seq: writes NUM_REGS delay registers over AXI4-Lite and reads each back to verify it.
`default_nettype none
module delay_cfg_seq
    import delay_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_REGS  = 4,
    parameter int          TIMEOUT   = 255
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    input  logic         start,
    input  logic [127:0] cfg_data,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [1:0]   err_code,
    output logic [1:0]   err_index,
    output logic [31:0]  m_axi_awaddr,
    output logic [2:0]   m_axi_awprot,
    output logic         m_axi_awvalid,
    input  logic         m_axi_awready,
    output logic [31:0]  m_axi_wdata,
    output logic [3:0]   m_axi_wstrb,
    output logic         m_axi_wvalid,
    input  logic         m_axi_wready,
    input  logic [1:0]   m_axi_bresp,
    input  logic         m_axi_bvalid,
    output logic         m_axi_bready,
    output logic [31:0]  m_axi_araddr,
    output logic [2:0]   m_axi_arprot,
    output logic         m_axi_arvalid,
    input  logic         m_axi_arready,
    input  logic [31:0]  m_axi_rdata,
    input  logic [1:0]   m_axi_rresp,
    input  logic         m_axi_rvalid,
    output logic         m_axi_rready
);

    localparam logic [1:0] LAST_IDX  = 2'(NUM_REGS - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

    state_t         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [127:0]   data_q, data_d;
    logic           awvalid_q, awvalid_d;
    logic           wvalid_q, wvalid_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           error_q, error_d;
    logic [1:0]     err_code_q, err_code_d;
    logic [1:0]     err_index_q, err_index_d;
    logic           fault;
    logic [1:0]     fault_code;
    logic [31:0]    word;
    logic           timed_out;
    logic           waiting;

    assign word      = data_q[{idx_q, 5'd0} +: 32];
    assign timed_out = (cnt_q == WAIT_LIMIT);
    assign waiting   = (state_q == WRITE) || (state_q == WRESP) ||
                       (state_q == RADDR) || (state_q == RDATA);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            data_q      <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            cnt_q       <= '0;
            error_q     <= 1'b0;
            err_code_q  <= '0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            cnt_q       <= cnt_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        error_d     = 1'b0;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        fault       = 1'b0;
        fault_code  = ERR_TIMEOUT;

        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d      = cfg_data;
                    idx_d       = '0;
                    err_code_d  = '0;
                    err_index_d = '0;
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                // AW and W channels complete independently, in any order
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready))
                    state_d = WRESP;
                else if (timed_out)
                    fault = 1'b1;
            end
            WRESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp == RESP_OKAY) begin
                        state_d = RADDR;
                    end else begin
                        fault      = 1'b1;
                        fault_code = ERR_BRESP;
                    end
                end else if (timed_out) begin
                    fault = 1'b1;
                end
            end
            RADDR: begin
                if (m_axi_arready)  state_d = RDATA;
                else if (timed_out) fault   = 1'b1;
            end
            RDATA: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != RESP_OKAY) begin
                        fault      = 1'b1;
                        fault_code = ERR_RRESP;
                    end else if (m_axi_rdata != word) begin
                        fault      = 1'b1;
                        fault_code = ERR_MISMATCH;
                    end else begin
                        state_d = NEXT;
                    end
                end else if (timed_out) begin
                    fault = 1'b1;
                end
            end
            NEXT: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end else begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WRITE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fault) begin
            state_d     = IDLE;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            error_d     = 1'b1;
            err_code_d  = fault_code;
            err_index_d = idx_q;
        end

        cnt_d = ((state_d != state_q) || !waiting) ? 8'd0 : cnt_q + 8'd1;
    end

    assign m_axi_awaddr  = BASE_ADDR + reg_offset(idx_q);
    assign m_axi_araddr  = m_axi_awaddr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_wdata   = word;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == WRESP);
    assign m_axi_arvalid = (state_q == RADDR);
    assign m_axi_rready  = (state_q == RDATA);

    assign busy      = waiting || (state_q == NEXT);
    assign done      = (state_q == FINISH);
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign err_index = err_index_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_cfg_seq.sv
// tb_delay_cfg_seq: directed checks of delay_cfg_seq against a configurable AXI4-Lite slave model.
`default_nettype none
module tb_delay_cfg_seq;

    localparam logic [31:0] TB_BASE = 32'h0000_1000;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         start = 1'b0;
    logic [127:0] cfg_data = '0;
    logic         busy, done, error;
    logic [1:0]   err_code, err_index;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [2:0]   awprot, arprot;
    logic [3:0]   wstrb;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;

    int checks = 0;
    int failures = 0;

    always #5 ACLK = ~ACLK;

    delay_cfg_seq #(.BASE_ADDR(TB_BASE), .NUM_REGS(4), .TIMEOUT(255)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // Slave behaviour knobs, set per test
    logic w_lead = 1'b0;
    int   bad_bresp_reg = -1;
    int   bad_rdata_reg = -1;
    int   hold_ar_reg = -1;

    logic        aw_got, w_got, w_seen;
    int          w_cnt;
    logic [31:0] aw_addr_q, w_data_q;
    logic [31:0] mem [4];
    logic [31:0] wr_addr_log [64];
    logic [31:0] wr_data_log [64];
    logic [31:0] rd_addr_log [64];
    int          wr_n, rd_n, drop_err, ar_cycles;
    logic        aw_hold, w_hold, ar_hold;

    wire         aw_now  = awvalid && awready;
    wire         w_now   = wvalid && wready;
    wire         ar_now  = arvalid && arready;
    wire [31:0]  wb_addr = aw_now ? awaddr : aw_addr_q;
    wire [31:0]  wb_data = w_now ? wdata : w_data_q;

    assign wready  = 1'b1;
    assign awready = !w_lead || (w_seen && w_cnt >= 2);
    assign arready = (hold_ar_reg < 0) || (int'(araddr[3:2]) != hold_ar_reg);

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_got <= 1'b0; w_got <= 1'b0; w_seen <= 1'b0; w_cnt <= 0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
            aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
        end else begin
            aw_hold <= awvalid && !awready;
            w_hold  <= wvalid && !wready;
            ar_hold <= arvalid && !arready;
            if ((aw_hold && !awvalid) || (w_hold && !wvalid) || (ar_hold && !arvalid))
                drop_err <= drop_err + 1;

            if (w_now) w_cnt <= 0;
            else if (w_seen) w_cnt <= w_cnt + 1;
            if (aw_now) w_seen <= 1'b0;
            else if (w_now) w_seen <= 1'b1;

            if (aw_now) begin aw_got <= 1'b1; aw_addr_q <= awaddr; end
            if (w_now)  begin w_got  <= 1'b1; w_data_q  <= wdata;  end
            if ((aw_got || aw_now) && (w_got || w_now) && !bvalid) begin
                bvalid <= 1'b1;
                bresp  <= (int'(wb_addr[3:2]) == bad_bresp_reg) ? 2'b10 : 2'b00;
                mem[wb_addr[3:2]]  <= wb_data;
                wr_addr_log[wr_n] <= wb_addr;
                wr_data_log[wr_n] <= wb_data;
                wr_n   <= wr_n + 1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end

            if (ar_now) begin
                rvalid <= 1'b1;
                rresp  <= 2'b00;
                rdata  <= (int'(araddr[3:2]) == bad_rdata_reg) ? (mem[araddr[3:2]] ^ 32'h1)
                                                               : mem[araddr[3:2]];
                rd_addr_log[rd_n] <= araddr;
                rd_n   <= rd_n + 1;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    initial begin wr_n = 0; rd_n = 0; drop_err = 0; ar_cycles = 0; end
    always @(negedge ACLK) if (arvalid) ar_cycles <= ar_cycles + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_seq(input logic [127:0] cfg, input bit poke,
                           output int cyc, output bit got_done, output bit got_err);
        @(negedge ACLK);
        start = 1'b1;
        cfg_data = cfg;
        @(posedge ACLK);
        cyc = 1; got_done = 1'b0; got_err = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge ACLK);
            if (k == 0) begin
                start = 1'b0;
                check("start_accept", {busy, err_code, err_index}, {1'b1, 4'b0});
                check("prot_strb", {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'hF});
            end
            if (poke && k == 3) begin start = 1'b1; cfg_data = ~cfg; end
            if (poke && k == 4) start = 1'b0;
            if (done || error) begin
                got_done = done;
                got_err  = error;
                break;
            end
            @(posedge ACLK);
            cyc++;
        end
        if (!got_done && !got_err) check("seq_bound", 1'b0, 1'b1);
    endtask

    logic [127:0] cfg_a;
    int  cyc, wb, rb, db, ab;
    bit  gd, ge, quiet;

    initial begin
        cfg_a = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF};

        // Reset values
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("reset_outs", {busy, done, error, err_code, err_index, awvalid, wvalid, bready, arvalid, rready}, '0);
        ARESETN = 1'b1;

        // Zero-wait slave: ordering, addresses, latency
        wb = wr_n; rb = rd_n;
        run_seq(cfg_a, 1'b0, cyc, gd, ge);
        check("basic_done", {gd, ge}, 2'b10);
        check("basic_latency", cyc, 21);
        check("basic_busy_done", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("basic_wr_addr", wr_addr_log[wb + i], TB_BASE + 32'(4 * i));
            check("basic_wr_data", wr_data_log[wb + i], cfg_a[32 * i +: 32]);
            check("basic_rd_addr", rd_addr_log[rb + i], TB_BASE + 32'(4 * i));
        end
        @(negedge ACLK);
        check("done_pulse", {done, error, busy}, 3'b000);

        // W accepted ahead of AW; a second start while busy must be ignored
        w_lead = 1'b1;
        wb = wr_n; db = drop_err;
        run_seq(cfg_a, 1'b1, cyc, gd, ge);
        check("wlead_done", {gd, ge}, 2'b10);
        check("wlead_count", wr_n - wb, 4);
        for (int i = 0; i < 4; i++) check("wlead_data", wr_data_log[wb + i], cfg_a[32 * i +: 32]);
        check("wlead_nodrop", drop_err - db, 0);
        w_lead = 1'b0;

        // Readback mismatch on reg 2
        bad_rdata_reg = 2;
        wb = wr_n; rb = rd_n;
        run_seq(cfg_a, 1'b0, cyc, gd, ge);
        check("mism_err", {gd, ge, busy}, 3'b010);
        check("mism_code", {err_code, err_index}, {2'd3, 2'd2});
        check("mism_noreg3", {32'(wr_n - wb), 32'(rd_n - rb)}, {32'd3, 32'd3});
        repeat (2) @(negedge ACLK);
        check("mism_hold", {error, err_code, err_index}, {1'b0, 2'd3, 2'd2});
        bad_rdata_reg = -1;

        // Bad BRESP on reg 1
        bad_bresp_reg = 1;
        rb = rd_n;
        run_seq(cfg_a, 1'b0, cyc, gd, ge);
        check("bresp_err", {gd, ge, busy}, 3'b010);
        check("bresp_code", {err_code, err_index}, {2'd1, 2'd1});
        check("bresp_cycle", cyc, 8);
        check("bresp_noread", rd_n - rb, 1);
        bad_bresp_reg = -1;

        // ARREADY stuck low on reg 0
        hold_ar_reg = 0;
        ab = ar_cycles;
        run_seq(cfg_a, 1'b0, cyc, gd, ge);
        check("tmo_err", {gd, ge}, 2'b01);
        check("tmo_code", {err_code, err_index, arvalid}, {2'd0, 2'd0, 1'b0});
        check("tmo_wait", ((ar_cycles - ab) >= 255) && ((ar_cycles - ab) <= 257), 1'b1);
        hold_ar_reg = -1;

        // Reset during reg 1 RDATA, then a fresh sequence
        @(negedge ACLK);
        start = 1'b1; cfg_data = cfg_a;
        @(negedge ACLK);
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (rready && araddr == TB_BASE + 32'h4) break;
            @(negedge ACLK);
        end
        check("rst_reach_rdata1", {rready, araddr}, {1'b1, TB_BASE + 32'h4});
        ARESETN = 1'b0;
        #1;
        check("rst_async", {busy, done, error, err_code, err_index, awvalid, wvalid, bready, arvalid, rready}, '0);
        repeat (2) @(negedge ACLK);
        check("rst_hold", {busy, done, error, awvalid, wvalid, bready, arvalid, rready}, '0);
        ARESETN = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge ACLK);
            if (done || error || busy) quiet = 1'b0;
        end
        check("rst_quiet", quiet, 1'b1);
        run_seq(cfg_a, 1'b0, cyc, gd, ge);
        check("rst_rerun", {gd, ge}, 2'b10);
        check("rst_rerun_latency", cyc, 21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/delay_cfg_seq.md
DELAY_CFG_SEQ -- requirements
Module: delay_cfg_seq

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of delay register 0.
REQ-002 SHALL have parameter NUM_REGS, default 4, meaning the number of consecutive 32-bit registers sequenced (1..4).
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles spent waiting on any single AXI handshake.
REQ-004 ACLK  in  1  sole clock; all logic on its rising edge.
REQ-005 ARESETN  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  single-cycle request to run one configure-and-verify sequence.
REQ-007 cfg_data  in  128  register images, with reg i at bits [32i+31:32i]; sampled when start is accepted.
REQ-008 busy  out  1  high from start acceptance until done or error pulses.
REQ-009 done  out  1  one-cycle pulse when all NUM_REGS registers are written and read back equal.
REQ-010 error  out  1  one-cycle pulse on failure; err_code and err_index are valid in the same cycle and held until the next start.
REQ-011 err_code  out  2  failure code: 1 = bad BRESP, 2 = bad RRESP, 3 = readback mismatch, 0 = timeout.
REQ-012 err_index  out  2  register index at failure.
REQ-013 The block SHALL present a 32-bit AXI4-Lite master port m_axi_*: AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY.

Function
REQ-014 FSM states SHALL be IDLE, WRITE, WRESP, RADDR, RDATA, NEXT and FINISH.
REQ-015 In IDLE, start SHALL latch cfg_data, clear idx and err_code/err_index, and go to WRITE; start is ignored while busy.
REQ-016 On entry to WRITE, AWVALID and WVALID SHALL assert together, with AWADDR = BASE_ADDR + 4*idx, WDATA = word idx, WSTRB = 4'hF and AWPROT = ARPROT = 3'b000.
REQ-017 AWVALID and WVALID SHALL each drop the cycle after their own READY is seen, independently; the FSM goes to WRESP when both have been accepted, in either order or in the same cycle.
REQ-018 In WRESP, BREADY SHALL be high; on BVALID, BRESP = 2'b00 goes to RADDR, and any other value gives error with code 1.
REQ-019 In RADDR, ARVALID SHALL be high with ARADDR = AWADDR of the same idx; on ARREADY the FSM goes to RDATA.
REQ-020 In RDATA, RREADY SHALL be high; on RVALID, a non-OKAY RRESP gives error code 2 and RDATA not equal to the written word gives error code 3; otherwise the FSM goes to NEXT.
REQ-021 NEXT SHALL increment idx; if idx = NUM_REGS-1 it goes to FINISH, otherwise to WRITE.
REQ-022 FINISH SHALL pulse done for one cycle and return to IDLE; error likewise pulses for one cycle and returns to IDLE.
REQ-023 VALID signals SHALL never drop before their READY, and no VALID SHALL depend combinationally on a READY.
REQ-024 An 8-bit wait counter SHALL clear on every state change; if it reaches TIMEOUT in WRITE, WRESP, RADDR or RDATA, the block SHALL drop all VALID/READY outputs and pulse error with code 0.
REQ-025 Only one transaction SHALL be outstanding, and a write is always fully responded before its readback address is issued.
REQ-026 Best-case latency for NUM_REGS = 4 with zero-wait slave: 4 x (WRITE 1 + WRESP 1 + RADDR 1 + RDATA 1 + NEXT 1) + FINISH 1 = 21 cycles from start to done.

Reset
REQ-027 While ARESETN = 0, the block SHALL be in IDLE with all m_axi VALID/READY = 0, busy/done/error = 0, err_code = 0, err_index = 0, idx = 0 and the counter = 0.
REQ-028 Reset asserted mid-sequence SHALL abort immediately, with no done or error pulse after release.

Structure
REQ-029 A shared package delay_pkg SHALL hold the FSM state enum, the RESP_OKAY/RESP_SLVERR constants, the err_code constants and the register offsets 0x0/0x4/0x8/0xC.
REQ-030 The block SHALL be a single module with no sub-module; address generation and compare are inline.

Verification
REQ-031 Data 0101FFFF/abcd0001/dead0011/beef0011 into a zero-wait slave model -> four writes then reads at BASE+0/4/8/C, done at cycle 21, error never asserted.
REQ-032 Slave accepts W three cycles before AW on every write -> the same data is written, done is asserted, and no VALID drops early.
REQ-033 Slave returns RDATA dead0010 for reg 2 -> error with err_code = 3 and err_index = 2, and no access to reg 3.
REQ-034 BRESP = 2'b10 on reg 1 -> error with err_code = 1 and err_index = 1 one cycle after BVALID, and busy drops.
REQ-035 ARREADY held low forever on reg 0 -> error with err_code = 0 after 255 wait cycles and ARVALID deasserted.
REQ-036 ARESETN pulsed low during reg 1 RDATA, then start again -> outputs are at reset values during reset, and the new sequence completes with done.
